// File: rtl/dcache_port_responder_pkg.sv
// Shared types for the dcache request-port responder: port structs, the
// pipeline stage record and the address-window check.
package dcache_port_responder_pkg;

  localparam int unsigned INDEX_W = 12;
  localparam int unsigned TAG_W   = 44;
  // Word index bits carried in a stage record: index bits [INDEX_W-1:3].
  localparam int unsigned WIDX_W  = INDEX_W - 3;

  typedef struct packed {
    logic [INDEX_W-1:0] address_index;
    logic [TAG_W-1:0]   address_tag;
    logic [63:0]        data_wdata;
    logic               data_req;
    logic               data_we;
    logic [7:0]         data_be;
    logic [1:0]         data_size;
    logic               kill_req;
    logic               tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [WIDX_W-1:0] word;
    logic              in_window;
    logic [63:0]       wdata;
    logic [7:0]        be;
  } stage_t;

  // True when addr falls in the span-sized window starting at base.
  function automatic logic addr_in_window(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] span);
    return (addr & ~(span - 64'd1)) == base;
  endfunction

endpackage

// File: rtl/dcache_port_if.sv
// Request/response bundle of the dcache load/store port.
interface dcache_port_if;
  import dcache_port_responder_pkg::*;

  dcache_req_i_t req_i;
  dcache_req_o_t req_o;

  modport master (output req_i, input  req_o);
  modport slave  (input  req_i, output req_o);
endinterface

// File: rtl/dcache_resp_mem.sv
// Byte-enable register array: combinational read, synchronous write,
// asynchronously cleared to zero.
module dcache_resp_mem
#(
  parameter int unsigned Depth = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_ni,
  input  logic                                    i_we,
  input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] i_waddr,
  input  logic [63:0]                             i_wdata,
  input  logic [7:0]                              i_be,
  input  logic [((Depth > 1) ? $clog2(Depth) : 1)-1:0] i_raddr,
  output logic [63:0]                             o_rdata
);

  logic [63:0] r_mem [Depth];

  // Write the enabled bytes of the addressed word; clear everything on reset.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      for (int b = 0; b < 8; b++) begin
        if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dcache_port_responder.sv
// Responder end of the dcache request port: grants requests, resolves the
// tag phase against a scratch memory and returns load data two cycles after
// the grant.
module dcache_port_responder
  import dcache_port_responder_pkg::*;
#(
  parameter int unsigned Depth    = 64,
  parameter logic [63:0] BaseAddr = 64'h8000_0000
) (
  input  logic         clk,
  input  logic         rst_ni,
  dcache_port_if.slave port,
  input  logic         stall_i,
  output logic         err_o,
  output logic [31:0]  loads_o
);

  localparam int unsigned AW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [63:0] SPAN = 64'(Depth) * 64'd8;

  dcache_req_i_t w_req;
  dcache_req_o_t w_rsp;
  stage_t        r_a;
  stage_t        r_b;
  logic [63:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_loads;

  logic [63:0]   w_addr;
  logic [63:0]   w_mem_rdata;
  logic [AW-1:0] w_word;
  logic          w_gnt;
  logic          w_in_win;
  logic          w_live;
  logic          w_load;
  logic          w_store;
  logic          w_err;
  logic          w_unused;

  assign w_req = port.req_i;

  // Grant is purely combinational and suppressed while reset is asserted.
  assign w_gnt = rst_ni & w_req.data_req & ~stall_i;

  // Tag cycle: the index came with the grant, the tag arrives now.
  assign w_addr   = 64'({w_req.address_tag, r_a.word, 3'b000});
  assign w_in_win = addr_in_window(w_addr, BaseAddr, SPAN);
  assign w_word   = r_a.word[AW-1:0];

  // kill_req overrides tag_valid; a live tag cycle is one not cancelled.
  assign w_live  = r_a.valid & ~w_req.kill_req;
  assign w_load  = w_live & w_req.tag_valid & ~r_a.we;
  assign w_store = w_live & w_req.tag_valid &  r_a.we & w_in_win;
  assign w_err   = w_live & (~w_req.tag_valid | ~w_in_win);

  dcache_resp_mem #(
    .Depth(Depth)
  ) u_mem (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .i_we    (w_store),
    .i_waddr (w_word),
    .i_wdata (r_a.wdata),
    .i_be    (r_a.be),
    .i_raddr (w_word),
    .o_rdata (w_mem_rdata)
  );

  // Stage A: capture the granted request while it waits for its tag.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_a <= '0;
    end else begin
      r_a.valid <= w_gnt;
      if (w_gnt) begin
        r_a.we    <= w_req.data_we;
        r_a.word  <= w_req.address_index[INDEX_W-1:3];
        r_a.wdata <= w_req.data_wdata;
        r_a.be    <= w_req.data_be;
      end
    end
  end

  // Stage B: register the load response; rdata holds between responses.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_b     <= '0;
      r_rdata <= '0;
    end else begin
      r_b.valid <= w_load;
      if (w_load) begin
        r_b.we        <= r_a.we;
        r_b.word      <= r_a.word;
        r_b.in_window <= w_in_win;
        r_b.wdata     <= r_a.wdata;
        r_b.be        <= r_a.be;
        r_rdata       <= w_in_win ? w_mem_rdata : 64'h0;
      end
    end
  end

  // Sticky error flag and saturating completed-load counter.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err   <= 1'b0;
      r_loads <= '0;
    end else begin
      if (w_err) r_err <= 1'b1;
      if (w_load && (r_loads != 32'hFFFF_FFFF)) r_loads <= r_loads + 32'd1;
    end
  end

  // Assemble the response side of the port.
  always_comb begin
    w_rsp             = '0;
    w_rsp.data_gnt    = w_gnt;
    w_rsp.data_rvalid = r_b.valid;
    w_rsp.data_rdata  = r_rdata;
  end

  assign port.req_o = w_rsp;
  assign err_o      = r_err;
  assign loads_o    = r_loads;

  // Fields carried for visibility but not consumed by the datapath.
  assign w_unused = ^{w_req.address_index[2:0], w_req.data_size, r_a.in_window,
                      r_b.we, r_b.word, r_b.in_window, r_b.wdata, r_b.be};

endmodule

// File: doc/dcache_port_responder.md
# dcache_port_responder

Responder (slave) end of the dcache load/store request port (`dcache_req_i_t` / `dcache_req_o_t`). It answers the index/grant, tag and rvalid phases from an internal word-addressed scratch memory. The block sits wherever a requester such as a load unit, store unit or prefetcher needs a deterministic, pipelined memory target: tightly coupled scratchpad, or bench/FPGA stand-in for the cache.

## Interface
- `Depth`, 64: number of 64-bit words; power of two, at least 2.
- `BaseAddr`, 64'h8000_0000: byte base of the window; aligned to `Depth*8`.
- `clk`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  dcache_req_i_t  requester port (index, tag, wdata, req, we, be, size, kill, tag_valid).
- `req_o`  out  dcache_req_o_t  grant, rvalid, rdata.
- `stall_i`  in  1  backpressure; forces `data_gnt` low.
- `err_o`  out  1  sticky error flag; cleared only by reset.
- `loads_o`  out  32  count of completed loads, saturating at 32'hFFFF_FFFF.

## Operation
- Full byte address = {address_tag, address_index}, truncated to 64 bits. Word select = addr[3 +: $clog2(Depth)].
- In-window: (addr & ~(Depth*8-1)) == BaseAddr.
- Two-stage pipeline:
  - A: granted, awaiting tag.
  - B: tag accepted, response pending.
- Grant: `data_gnt = data_req & ~stall_i`, combinational. One request per cycle; throughput 1/cycle.
- The cycle after a grant is the tag cycle. In that cycle exactly one of the following holds:
  - `kill_req=1`: request cancelled. No write, no rvalid, no counter change. Takes priority over `tag_valid`.
  - `tag_valid=1`, load (`we=0`): memory read in the tag cycle and registered. rvalid and rdata appear next cycle. `loads_o` increments.
  - `tag_valid=1`, store (`we=1`): bytes with `be[i]=1` written at the end of the tag cycle. No rvalid.
  - Neither: request dropped, `err_o` set.
- Loads always return the full aligned 64-bit word; `data_size` and `be` are ignored for loads.
- Out-of-window load returns rdata 64'h0 with rvalid and sets `err_o`. An out-of-window store is dropped and sets `err_o`.
- Store-to-load forwarding is not needed. A load whose tag cycle follows a store's tag cycle to the same word reads the updated value.
- Memory resets to all zeros.

## Timing
- Load latency: req+gnt in cycle N; tag in N+1; rvalid/rdata in N+2.
- Back-to-back: a grant in N+1 overlaps the tag of N. rvalid can be high on consecutive cycles.
- `stall_i` affects grant only. Requests already in A or B always complete; rvalid cannot be backpressured.
- `data_rdata` holds its last value when rvalid=0.
- Reset values: rvalid 0, rdata 0, err_o 0, loads_o 0, stages A/B empty. `data_gnt` is combinational: 0 when `data_req`=0, or while `rst_ni`=0.
- Reset mid-operation clears stages A/B immediately. A load in flight never produces rvalid.

## Structure
- Shared package (wt_cache_pkg or a new responder package):
  - stage record typedef (valid, we, word index, in_window, wdata, be);
  - helper function for the window check.
- One sub-module, `dcache_resp_mem`:
  - `Depth` x 64 byte-enable register array;
  - one combinational read port, one synchronous write port;
  - async reset to zero.
- Top level: grant logic, stage A/B registers, error/counter logic.

## Test plan
- Store `0x1122334455667788` to `0x8000_0010` with be=FF; then load `0x8000_0010`. Required: rvalid two cycles after the load grant, rdata=`0x1122334455667788`, `loads_o`=1.
- Store with be=0x0F, wdata `0xFFFFFFFF_AAAAAAAA`, over the previous value. The next load returns `0x11223344_AAAAAAAA`.
- Four back-to-back loads, one per cycle, to words 0..3 preloaded with 1..4. Required: rvalid high for four consecutive cycles, rdata 1,2,3,4.
- Hold `stall_i=1` for 3 cycles with `data_req=1`. Required: no grant during the stall; grant in the first cycle after release; the in-flight prior load still returns on time.
- `kill_req=1` in the tag cycle of a load, and separately of a store to word 5. Required: no rvalid, word 5 unchanged, `loads_o` unchanged, `err_o`=0.
- Load `0x0000_1000` (out of window). Required: rvalid with rdata 0, `err_o`=1. A grant followed by no tag and no kill also sets `err_o`. Assert `rst_ni` low mid-load: no rvalid; `err_o`=0 and `loads_o`=0 after reset.
